dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a data memory and a
// memory-mapped I/O register block.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   c_*                   - CPU requester (port 0): req/we/addr/wdata in, gnt/rvalid/rdata out
//   l_*                   - loader/debug requester (port 1), same shape as c_*
//   mem_we/addr/wdata     - data memory strobes, mem_rdata returns one cycle after the address
//   io_we/addr/wdata      - I/O register block strobes, io_rdata returns one cycle after the address
//   err_clr, err          - clear input and sticky bad-access flag
module dmem_arbiter #(
    parameter int                 DBITS          = 32,
    parameter int                 DMEM_WORD_BITS = 11,
    parameter logic [DBITS-1:0]   IO_BASE        = 32'hF0000000
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      c_req,
    input  logic                      c_we,
    input  logic [DBITS-1:0]          c_addr,
    input  logic [DBITS-1:0]          c_wdata,
    output logic                      c_gnt,
    output logic                      c_rvalid,
    output logic [DBITS-1:0]          c_rdata,

    input  logic                      l_req,
    input  logic                      l_we,
    input  logic [DBITS-1:0]          l_addr,
    input  logic [DBITS-1:0]          l_wdata,
    output logic                      l_gnt,
    output logic                      l_rvalid,
    output logic [DBITS-1:0]          l_rdata,

    output logic                      mem_we,
    output logic [DMEM_WORD_BITS-1:0] mem_addr,
    output logic [DBITS-1:0]          mem_wdata,
    input  logic [DBITS-1:0]          mem_rdata,

    output logic                      io_we,
    output logic [2:0]                io_addr,
    output logic [DBITS-1:0]          io_wdata,
    input  logic [DBITS-1:0]          io_rdata,

    input  logic                      err_clr,
    output logic                      err
);

    // Where the read data of the previous cycle's grant comes from.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_IO
    } src_t;

    logic             last_gnt;   // 1: loader was granted most recently
    logic             c_rv_q;
    logic             l_rv_q;
    src_t             src_q;
    logic             err_q;

    logic             any_gnt;
    logic             sel_we;
    logic [DBITS-1:0] sel_addr;
    logic [DBITS-1:0] sel_wdata;
    logic             aligned;
    logic             mem_legal;
    logic             io_legal;
    logic             illegal;
    logic [DBITS-1:0] rd_mux;

    // Grant: a lone requester wins; on contention the port not granted last wins.
    always_comb begin
        c_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!reset) begin
            if (c_req && (!l_req || last_gnt))
                c_gnt = 1'b1;
            else if (l_req)
                l_gnt = 1'b1;
        end
    end

    assign any_gnt   = c_gnt | l_gnt;
    assign sel_we    = l_gnt ? l_we    : c_we;
    assign sel_addr  = l_gnt ? l_addr  : c_addr;
    assign sel_wdata = l_gnt ? l_wdata : c_wdata;

    assign aligned   = (sel_addr[1:0] == 2'b00);
    assign mem_legal = aligned && (sel_addr[DBITS-1:DMEM_WORD_BITS+2] == '0);
    assign io_legal  = aligned && (sel_addr[DBITS-1:DBITS-4] == IO_BASE[DBITS-1:DBITS-4]);
    assign illegal   = !(mem_legal || io_legal);

    assign mem_we    = any_gnt && sel_we && mem_legal;
    assign io_we     = any_gnt && sel_we && io_legal;
    assign mem_addr  = sel_addr[DMEM_WORD_BITS+1:2];
    assign io_addr   = sel_addr[4:2];
    assign mem_wdata = sel_wdata;
    assign io_wdata  = sel_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            c_rv_q   <= 1'b0;
            l_rv_q   <= 1'b0;
            src_q    <= SRC_NONE;
            err_q    <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            c_rv_q <= c_gnt && !c_we;
            l_rv_q <= l_gnt && !l_we;
            if (any_gnt)
                last_gnt <= l_gnt;
            if (!any_gnt || sel_we)
                src_q <= SRC_NONE;
            else if (mem_legal)
                src_q <= SRC_MEM;
            else if (io_legal)
                src_q <= SRC_IO;
            else
                src_q <= SRC_NONE;
            // A new illegal grant takes priority over a clear in the same cycle.
            if (any_gnt && illegal)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (src_q)
            SRC_MEM: rd_mux = mem_rdata;
            SRC_IO:  rd_mux = io_rdata;
            default: rd_mux = '0;
        endcase
    end

    // A read granted just before reset rises is dropped: reset masks the
    // already-registered rvalid so it never becomes visible.
    assign c_rvalid = c_rv_q && !reset;
    assign l_rvalid = l_rv_q && !reset;
    assign c_rdata  = c_rvalid ? rd_mux : '0;
    assign l_rdata  = l_rvalid ? rd_mux : '0;
    assign err      = err_q;

endmodule
